// File: rtl/irrigation_sequencer.sv
// Registered actuator sequencer: turns per-cycle irrigation requests into mutually
// exclusive actuator enables with min-on times, fill timeout, blinking alarm and latched fault.
module irrigation_sequencer #(
  parameter int MIN_ON    = 8,
  parameter int MAX_FILL  = 64,
  parameter int BLINK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ve_req,
  input  logic       bs_req,
  input  logic       vs_req,
  input  logic       al_in,
  input  logic       e_in,
  input  logic       ack,
  output logic       valve_en,
  output logic       pump_en,
  output logic       drip_en,
  output logic       alarm_led,
  output logic       error_led,
  output logic       fill_to,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    ALARM    = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic [15:0] MIN_LAST   = 16'(MIN_ON - 1);
  localparam logic [15:0] FILL_LAST  = 16'(MAX_FILL - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

  state_t      cur, nxt;
  logic [15:0] cnt, bcnt;
  logic        blink, ve_q;
  logic        fill_set, fill_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= IDLE;
      cnt     <= '0;
      bcnt    <= '0;
      blink   <= 1'b0;
      ve_q    <= 1'b0;
      fill_to <= 1'b0;
    end else begin
      cur  <= nxt;
      ve_q <= ve_req;
      if (nxt != cur)           cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      // Blink phase restarts lit on every ALARM entry
      if (nxt == ALARM && cur != ALARM) begin
        blink <= 1'b1;
        bcnt  <= '0;
      end else if (nxt == ALARM) begin
        if (bcnt == BLINK_LAST) begin
          blink <= ~blink;
          bcnt  <= '0;
        end else begin
          bcnt <= bcnt + 16'd1;
        end
      end else begin
        blink <= 1'b0;
        bcnt  <= '0;
      end
      if (fill_set)      fill_to <= 1'b1;
      else if (fill_clr) fill_to <= 1'b0;
    end
  end

  always_comb begin
    nxt       = cur;
    fill_set  = 1'b0;
    fill_clr  = 1'b0;
    if (e_in) begin
      nxt = FAULT;
    end else begin
      case (cur)
        IDLE: begin
          if (al_in)       nxt = ALARM;
          else if (ve_req) nxt = FILL;
          else if (bs_req) nxt = SPRINKLE;
          else if (vs_req) nxt = DRIP;
        end
        FILL: begin
          if (al_in) nxt = ALARM;
          else if (ve_req && cnt == FILL_LAST) begin
            nxt      = FAULT;
            fill_set = 1'b1;
          end else if (!ve_req && cnt >= MIN_LAST) nxt = IDLE;
        end
        SPRINKLE: begin
          if (al_in)                          nxt = ALARM;
          else if (!bs_req && cnt >= MIN_LAST) nxt = IDLE;
        end
        DRIP: begin
          if (al_in)                          nxt = ALARM;
          else if (!vs_req && cnt >= MIN_LAST) nxt = IDLE;
        end
        ALARM: if (!al_in) nxt = IDLE;
        FAULT: begin
          if (ack) begin
            nxt      = IDLE;
            fill_clr = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end

    valve_en  = (cur == FILL) || (cur == ALARM && ve_q);
    pump_en   = (cur == SPRINKLE);
    drip_en   = (cur == DRIP);
    alarm_led = (cur == ALARM) && blink;
    error_led = (cur == FAULT);
    state     = cur;
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboard bench for irrigation_sequencer: directed scenarios then random traffic,
// checked against an age-based behavioural model.
module tb_irrigation_sequencer;
  localparam int MIN_ON = 8, MAX_FILL = 64, BLINK_DIV = 4;

  logic clk = 1'b0;
  logic rst, ve_req, bs_req, vs_req, al_in, e_in, ack;
  logic valve_en, pump_en, drip_en, alarm_led, error_led, fill_to;
  logic [2:0] state;

  int n_chk = 0, n_fail = 0;
  logic [9:0] expq[$];

  // model state: mode code, cycles spent in mode, sticky timeout, last ve_req
  int   m_cur = 0, m_age = 0;
  logic m_fto = 1'b0, m_vq = 1'b0;

  irrigation_sequencer #(.MIN_ON(MIN_ON), .MAX_FILL(MAX_FILL), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .ve_req(ve_req), .bs_req(bs_req), .vs_req(vs_req),
    .al_in(al_in), .e_in(e_in), .ack(ack), .valve_en(valve_en), .pump_en(pump_en),
    .drip_en(drip_en), .alarm_led(alarm_led), .error_led(error_led), .fill_to(fill_to),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int   nx;
    logic req, lit;
    if (rst) begin
      m_cur = 0; m_age = 0; m_fto = 1'b0; m_vq = 1'b0;
    end else begin
      nx  = m_cur;
      req = (m_cur == 1) ? ve_req : (m_cur == 2) ? bs_req : vs_req;
      if (e_in) nx = 5;
      else if (m_cur == 0) nx = al_in ? 4 : ve_req ? 1 : bs_req ? 2 : vs_req ? 3 : 0;
      else if (m_cur >= 1 && m_cur <= 3) begin
        if (al_in) nx = 4;
        else if (m_cur == 1 && ve_req && m_age == MAX_FILL - 1) begin nx = 5; m_fto = 1'b1; end
        else if (!req && m_age >= MIN_ON - 1) nx = 0;
      end
      else if (m_cur == 4) begin if (!al_in) nx = 0; end
      else if (m_cur == 5) begin if (ack) begin nx = 0; m_fto = 1'b0; end end
      m_age = (nx != m_cur) ? 0 : (m_age < 65535 ? m_age + 1 : m_age);
      m_cur = nx;
      m_vq  = ve_req;
    end
    lit = (m_cur == 4) && (((m_age / BLINK_DIV) % 2) == 0);
    expq.push_back({3'(m_cur), m_fto, (m_cur == 5), lit, (m_cur == 3), (m_cur == 2),
                    (m_cur == 1) || (m_cur == 4 && m_vq)});
  end

  always @(posedge clk) begin
    logic [9:0] exp_v, got;
    #1;
    got = {state, fill_to, error_led, alarm_led, drip_en, pump_en, valve_en};
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got=%b required an expected entry", $time, got);
    end else begin
      exp_v = expq.pop_front();
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t {state,fto,err,alm,drip,pump,valve} got=%b required=%b",
                 $time, got, exp_v);
      end
    end
    n_chk++;
    if ((pump_en && drip_en) || (valve_en && (pump_en || drip_en))) begin
      n_fail++;
      $display("FAIL exclusion t=%0t valve=%b pump=%b drip=%b required at most one",
               $time, valve_en, pump_en, drip_en);
    end
  end

  // v = {rst, ve_req, bs_req, vs_req, al_in, e_in, ack}
  task automatic drv(input logic [6:0] v, input int n);
    {rst, ve_req, bs_req, vs_req, al_in, e_in, ack} = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drv(7'b1111111, 3);
    drv(7'b0010000, 1);  drv(7'b0000000, 12);
    drv(7'b0110000, 20); drv(7'b0010000, 15); drv(7'b0000000, 12);
    drv(7'b0100000, 100); drv(7'b0000000, 3); drv(7'b0000001, 1); drv(7'b0000000, 3);
    drv(7'b0001000, 3);  drv(7'b0000100, 10); drv(7'b0000000, 5);
    drv(7'b0010000, 3);  drv(7'b0000010, 2);  drv(7'b0000011, 2);
    drv(7'b0000001, 1);  drv(7'b0000000, 3);
    drv(7'b0100000, 31); drv(7'b1100000, 1);  drv(7'b0100000, 70);
    drv(7'b0000001, 1);  drv(7'b0000000, 3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ve_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  bs_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  vs_req = 1'($urandom_range(0, 1));
      al_in = al_in ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 59) == 0);
      e_in  = e_in ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    drv(7'b0000000, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
